// File: rtl/inst_i_enc.sv
// inst_i_enc: I-type instruction encoder with output FIFO; define INST_I_ENC_CHECK_EN for funct3/imm legality checks
module inst_i_enc #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rd,
    input  logic [11:0]              imm_I,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              instruction_word,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic [ERRW-1:0]          err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [6:0] LOAD = 7'b0000011, OP_IMM = 7'b0010011, JALR = 7'b1100111;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          legal, acc, push, pop;
`ifdef INST_I_ENC_CHECK_EN
    always_comb
        legal = (opcode == LOAD)   ? !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) :
                (opcode == JALR)   ? funct3 == 3'b000 :
                (opcode == OP_IMM) ? ((funct3 == 3'b001) ? imm_I[11:5] == 7'b0000000 :
                                      (funct3 == 3'b101) ? (imm_I[11:5] == 7'b0000000 || imm_I[11:5] == 7'b0100000) :
                                      1'b1) :
                1'b0;
`else
    always_comb legal = opcode == LOAD || opcode == OP_IMM || opcode == JALR;
`endif
    assign in_ready         = count != FULL;
    assign out_valid        = count != '0;
    assign acc              = in_valid && in_ready;
    assign push             = acc && legal;
    assign pop              = out_valid && out_ready;
    assign instruction_word = out_valid ? mem[rp] : '0;
    always_ff @(posedge clk)
        if (push) mem[wp] <= {imm_I, rs1, funct3, rd, opcode};
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            err   <= acc && !legal;
            if (acc && !legal && err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
        end
    end
endmodule

// File: tb/tb_inst_i_enc.sv
// tb_inst_i_enc: table vectors, directed corner sequences and random traffic against a queue model
module tb_inst_i_enc;
    localparam int DEPTH = 4;
`ifdef INST_I_ENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, err;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [4:0] rs1 = '0, rd = '0;
    logic [11:0] imm_I = '0;
    logic [31:0] instruction_word;
    logic [2:0] count;
    logic [7:0] err_cnt;
    int checks = 0, errors = 0;
    logic [31:0] q[$];
    bit m_err = 0;
    int m_ecnt = 0;

    inst_i_enc #(.DEPTH(DEPTH), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rs1(rs1), .rd(rd), .imm_I(imm_I),
        .out_valid(out_valid), .out_ready(out_ready), .instruction_word(instruction_word),
        .count(count), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [31:0] word;
        bit          lg;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, a, e);
        end
    endtask

    function automatic bit ref_legal(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm);
        case (op)
            7'h03:   return !CHK || !(f3 inside {3'd3, 3'd6, 3'd7});
            7'h67:   return !CHK || f3 == 3'd0;
            7'h13:   return !CHK || (f3 == 3'd1 ? imm[11:5] == 7'h00 :
                                     f3 == 3'd5 ? (imm[11:5] == 7'h00 || imm[11:5] == 7'h20) : 1'b1);
            default: return 1'b0;
        endcase
    endfunction

    // Compare the pre-edge state at negedge, then advance the model with the inputs seen at the edge.
    task automatic cyc();
        bit acc, lg;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("word", instruction_word, q.size() > 0 ? q[0] : 32'h0);
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 0;
            m_ecnt = 0;
        end else begin
            acc = in_valid && q.size() < DEPTH;
            lg = ref_legal(opcode, funct3, imm_I);
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (acc && lg) q.push_back(imm_I * 32'h100000 + rs1 * 32'h8000 + funct3 * 32'h1000 + rd * 32'h80 + opcode);
            m_err = acc && !lg;
            if (m_err && m_ecnt < 255) m_ecnt++;
        end
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] s1,
                         input logic [4:0] d, input logic [11:0] imm);
        opcode = op; funct3 = f3; rs1 = s1; rd = d; imm_I = imm;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    vec_t tbl[8];
    int nerr;

    initial begin
        tbl[0] = '{7'h03, 3'd0, 5'd19, 5'd7, 12'h209, 32'h20998383, 1'b1};
        tbl[1] = '{7'h03, 3'd7, 5'd1,  5'd6, 12'h76D, 32'h76D0F303, !CHK};
        tbl[2] = '{7'h13, 3'd5, 5'd1,  5'd2, 12'h405, 32'h4050D113, 1'b1};
        tbl[3] = '{7'h33, 3'd0, 5'd3,  5'd4, 12'h000, 32'h0,        1'b0};
        tbl[4] = '{7'h67, 3'd0, 5'd5,  5'd1, 12'h004, 32'h004280E7, 1'b1};
        tbl[5] = '{7'h67, 3'd1, 5'd5,  5'd1, 12'h004, 32'h004290E7, !CHK};
        tbl[6] = '{7'h13, 3'd1, 5'd2,  5'd3, 12'h403, 32'h40311193, !CHK};
        tbl[7] = '{7'h13, 3'd0, 5'd31, 5'd31, 12'hFFF, 32'hFFFF8F93, 1'b1};
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);

        nerr = 0;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].op, tbl[i].f3, tbl[i].rs1, tbl[i].rd, tbl[i].imm);
            in_valid = 1'b1;
            cyc();
            in_valid = 1'b0;
            if (tbl[i].lg) begin
                chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("tbl%0d_word", i), instruction_word, tbl[i].word);
                chk($sformatf("tbl%0d_count", i), 32'(count), 32'd1);
                chk($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
            end else begin
                nerr++;
                chk($sformatf("tbl%0d_count", i), 32'(count), 32'd0);
                chk($sformatf("tbl%0d_err", i), 32'(err), 32'd1);
                chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'd1);
            end
            chk($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), 32'(nerr));
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            chk($sformatf("tbl%0d_err_clr", i), 32'(err), 32'd0);
        end

        // Saturation of the reject counter
        do_reset();
        drive(7'h33, 3'd0, 5'd0, 5'd0, 12'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 257; i++) cyc();
        in_valid = 1'b0;
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_count", 32'(count), 32'd0);
        cyc();
        chk("sat_err_drop", 32'(err), 32'd0);

        // Fill, pop-only while full, then concurrent push/pop across the wrap
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(7'h03, 3'd0, 5'(i), 5'(i + 8), 12'(i * 3 + 1));
            cyc();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_head", instruction_word, 32'h00100403);
        drive(7'h13, 3'd0, 5'd9, 5'd9, 12'h0AA);
        out_ready = 1'b1;
        cyc();
        chk("pop_only_count", 32'(count), 32'd3);
        cyc();
        chk("pushpop_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset with data and a nonzero reject count pending
        drive(7'h33, 3'd0, 5'd0, 5'd0, 12'h0);
        in_valid = 1'b1;
        cyc();
        drive(7'h03, 3'd2, 5'd4, 5'd5, 12'h010);
        for (int i = 0; i < 3; i++) cyc();
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_word", instruction_word, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_word", instruction_word, 32'h01022283);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0: opcode = 7'h03;
                1: opcode = 7'h13;
                2: opcode = 7'h67;
                default: opcode = 7'($urandom);
            endcase
            funct3 = 3'($urandom);
            rs1 = 5'($urandom);
            rd = 5'($urandom);
            imm_I = 12'($urandom);
            if ($urandom_range(0, 1) == 0) imm_I[11:5] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            rst = 1'($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_i_enc.md
Name: inst_i_enc

Overview:
- Sequential I-type instruction encoder, the counterpart of the I-type field decoder.
- Accepts opcode, funct3, rs1, rd and imm_I fields over a valid/ready handshake.
- Packs each accepted set of fields into a 32-bit RV32I instruction_word as {imm_I[11:0], rs1, funct3, rd, opcode}.
- Buffers encoded words in a small FIFO for the instruction-memory loader or testbench driver. Rejects illegal encodings and reports them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  field set presented.
- in_ready  output  1  encoder can accept; equals !full.
- opcode  input  7  major opcode.
- funct3  input  3  minor opcode.
- rs1  input  5  source register.
- rd  input  5  destination register.
- imm_I  input  12  immediate.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer takes the head word.
- instruction_word  output  32  FIFO head word; 0 when empty.
- count  output  $clog2(DEPTH)+1  occupancy.
- err  output  1  one-cycle pulse when an illegal field set is consumed.
- err_cnt  output  ERRW  saturating count of rejects.

Behaviour:
- Reset (rst=1 at an edge) clears the pointers and sets count=0, out_valid=0, instruction_word=0, err=0, err_cnt=0. Reset takes priority over any push or pop in the same cycle, and FIFO contents are discarded.
- Accept occurs when in_valid && in_ready at an edge.
- Legal opcodes: 0000011 (LOAD), 0010011 (OP-IMM), 1100111 (JALR). Any other opcode is illegal.
- Accepted and legal: the packed word is written at the write pointer and count increments. out_valid is high in the cycle after the accept edge, giving 1-cycle latency.
- Accepted and illegal: the fields are consumed but nothing is written. err=1 for exactly the next cycle. err_cnt increments and saturates at all-ones.
- Pop occurs when out_valid && out_ready at an edge; the read pointer advances.
- Simultaneous push and pop: both happen and count is unchanged.
- Full (count==DEPTH): in_ready=0 even if out_ready=1, so there is no bypass and no write while full.
- Empty: out_ready is ignored.
- Pointers wrap modulo DEPTH.
- instruction_word is combinational from the head entry and masked to 0 when empty.
- err is registered and deasserts the cycle after the pulse unless another illegal set is accepted in that cycle.

Optional Feature:
- Macro: INST_I_ENC_CHECK_EN.
- With the macro defined, these field sets are also illegal:
  - LOAD with funct3 in {011, 110, 111}.
  - JALR with funct3 != 000.
  - OP-IMM with funct3=001 and imm_I[11:5] != 0000000.
  - OP-IMM with funct3=101 and imm_I[11:5] not in {0000000, 0100000}.
- Without the macro, only the opcode check applies and every other field is packed verbatim.

Test Plan:
- Legal LOAD encode: after reset, send imm=0x209, rs1=19, f3=000, rd=7, op=0000011 -> out_valid=1 one cycle later, instruction_word=0x20998383, count=1.
- LOAD funct3=111: send imm=0x76D, rs1=1, f3=111, rd=6, op=0000011.
  - Macro undefined -> word 0x76D0F303 is enqueued.
  - Macro defined -> no enqueue, err pulses once, err_cnt=1.
- SRAI encode: send imm=0x405, rs1=1, f3=101, rd=2, op=0010011 -> 0x4050D113 with the macro either defined or undefined.
- Illegal opcode 0110011 -> in_ready stays 1, count unchanged, err pulse 1 cycle, err_cnt increments. 256 such rejects with ERRW=8 -> err_cnt holds at 0xFF.
- Fill and drain, with DEPTH=4 and out_ready=0:
  - 4 legal pushes -> count=4, in_ready=0.
  - Then in_valid=1, out_ready=1 -> pop only, count=3.
  - Next cycle push and pop together -> count=3, with words emerging in FIFO order across pointer wrap.
- Reset mid-operation: with count=3, assert rst for one edge -> count=0, out_valid=0, instruction_word=0, err_cnt=0. A following push then appears 1 cycle later.
